// File: rtl/uart_rx_assembler.sv
// 8N1 UART receiver that packs bytes into a 14-byte message for the TX echo path.
// Optional idle-gap message close: define UART_RX_TIMEOUT_EN.
module uart_rx_assembler #(
  parameter int         CLOCK_SPEED  = 1000000,
  parameter int         BAUD_RATE    = 9600,
  parameter logic [7:0] TERMINATOR   = 8'h0D,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_rxSerial,
  output logic [111:0] o_rxData,
  output logic [7:0]   o_rxDataLength,
  output logic         o_rxBusy,
  output logic         o_rxDone,
  output logic         o_rxError
);

  localparam int CLKS_PER_BIT = CLOCK_SPEED / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT * TIMEOUT_BITS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    s_IDLE,
    s_START,
    s_DATA,
    s_STOP,
    s_WAIT_HIGH
  } rxState_t;

  rxState_t       state;
  logic           rxMeta;
  logic           rxSync;
  logic [CW-1:0]  clkCount;
  logic [2:0]     bitIndex;
  logic [7:0]     rxShift;
  logic           byteValid;
  logic           errValid;
  logic [111:0]   buffer;
  logic [7:0]     count;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
    end else begin
      rxMeta <= i_rxSerial;
      rxSync <= rxMeta;
    end
  end

  // Receiver FSM: mid-bit sampling, one byte or error event per frame
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state     <= s_IDLE;
      clkCount  <= '0;
      bitIndex  <= '0;
      rxShift   <= '0;
      byteValid <= 1'b0;
      errValid  <= 1'b0;
    end else begin
      byteValid <= 1'b0;
      errValid  <= 1'b0;
      case (state)
        s_IDLE: begin
          clkCount <= '0;
          bitIndex <= '0;
          if (!rxSync) state <= s_START;
        end
        s_START: begin
          if (clkCount == HALF_LAST) begin
            clkCount <= '0;
            state    <= rxSync ? s_IDLE : s_DATA;
          end else begin
            clkCount <= clkCount + CW'(1);
          end
        end
        s_DATA: begin
          if (clkCount == BIT_LAST) begin
            clkCount <= '0;
            rxShift  <= {rxSync, rxShift[7:1]};
            if (bitIndex == 3'd7) state <= s_STOP;
            else bitIndex <= bitIndex + 3'd1;
          end else begin
            clkCount <= clkCount + CW'(1);
          end
        end
        s_STOP: begin
          if (clkCount == BIT_LAST) begin
            clkCount <= '0;
            if (rxSync) begin
              byteValid <= 1'b1;
              state     <= s_IDLE;
            end else begin
              errValid <= 1'b1;
              state    <= s_WAIT_HIGH;
            end
          end else begin
            clkCount <= clkCount + CW'(1);
          end
        end
        s_WAIT_HIGH: begin
          if (rxSync) state <= s_IDLE;
        end
        default: state <= s_IDLE;
      endcase
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST =
    CW'(CLKS_PER_BIT * TIMEOUT_BITS - 1);

  logic [CW-1:0] idleCount;
  logic          timeoutHit;

  assign timeoutHit = (state == s_IDLE) && !byteValid &&
                      (count != 8'd0) && (idleCount == TO_LAST);

  // Idle-gap timer: runs only while bytes are pending and the line is quiet
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      idleCount <= '0;
    end else if (byteValid || state != s_IDLE || count == 8'd0) begin
      idleCount <= '0;
    end else if (idleCount != TO_LAST) begin
      idleCount <= idleCount + CW'(1);
    end
  end
`endif

  // Message assembler: shift bytes in, publish on terminator, full or timeout
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      buffer         <= '0;
      count          <= '0;
      o_rxData       <= '0;
      o_rxDataLength <= '0;
      o_rxDone       <= 1'b0;
      o_rxError      <= 1'b0;
    end else begin
      o_rxDone  <= 1'b0;
      o_rxError <= errValid;
      if (errValid) begin
        buffer <= '0;
        count  <= '0;
      end else if (byteValid) begin
        if (rxShift == TERMINATOR) begin
          if (count != 8'd0) begin
            o_rxData       <= buffer;
            o_rxDataLength <= count;
            o_rxDone       <= 1'b1;
          end
          buffer <= '0;
          count  <= '0;
        end else if (count == 8'd13) begin
          o_rxData       <= {buffer[103:0], rxShift};
          o_rxDataLength <= 8'd14;
          o_rxDone       <= 1'b1;
          buffer         <= '0;
          count          <= '0;
        end else begin
          buffer <= {buffer[103:0], rxShift};
          count  <= count + 8'd1;
        end
      end
`ifdef UART_RX_TIMEOUT_EN
      else if (timeoutHit) begin
        o_rxData       <= buffer;
        o_rxDataLength <= count;
        o_rxDone       <= 1'b1;
        buffer         <= '0;
        count          <= '0;
      end
`endif
    end
  end

  // Busy while a frame is in flight or bytes are still pending
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) o_rxBusy <= 1'b0;
    else o_rxBusy <= (state != s_IDLE) || (count != 8'd0);
  end

endmodule
